fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/mips_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/fetch_queue.sv | 136 +++++++++++++
 tb/tb_fetch_queue.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and FSM state type for the instruction fetch path
// Contents: RESET_PC, NOP_INSTR, INSTR_W, fetch_state_e and a word-alignment helper.
package mips_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // IDLE: nothing outstanding, REQ: live request, DRAIN: stale request whose data is dropped
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry FIFO holding {pc, instruction} pairs for the fetch queue
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   push, push_data   write an entry (ignored when full)
//   pop               drop the head entry (ignored when empty)
//   flush             empty the FIFO at the next edge; overrides push/pop
//   head_data         current head entry (meaningless when empty)
//   count             number of stored entries, 0..DEPTH
//   empty, full       occupancy flags
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // DEPTH is a power of two, so pointers wrap naturally
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is never presented while empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch engine with a DEPTH-entry instruction queue
// Optional feature macro: FETCH_STALL_CNT_EN adds the stall_cnt output.
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   redirect, redirect_pc         one-cycle branch/jump redirect and its target
//   imem_req, imem_addr           instruction memory request, held until imem_ack
//   imem_ack, imem_rdata          memory completion and data (same cycle)
//   instr_valid, instr_ready      decode handshake on the queue head
//   instr, instr_pc               head instruction word and its address
//   stall_cnt                     (FETCH_STALL_CNT_EN) saturating count of unacked request cycles
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  imem_addr_q, imem_addr_d;
  logic         imem_req_q, imem_req_d;

  logic                   fifo_push, fifo_pop;
  logic [2*INSTR_W-1:0]   fifo_head;
  logic [CW-1:0]          fifo_count, count_after;
  logic                   fifo_empty, fifo_full;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * INSTR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({fetch_pc_q, imem_rdata}),
    .pop       (fifo_pop),
    .flush     (redirect),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // The head is hidden during a redirect so decode never consumes wrong-path work
  assign instr_valid = !fifo_empty && !redirect;
  assign instr       = fifo_empty ? NOP_INSTR : fifo_head[INSTR_W-1:0];
  assign instr_pc    = fifo_empty ? 32'h0 : fifo_head[2*INSTR_W-1:INSTR_W];
  assign fifo_pop    = instr_valid && instr_ready;
  // In REQ, fetch_pc equals the outstanding address, so it tags the pushed word
  assign fifo_push   = (state_q == ST_REQ) && imem_ack && !redirect;
  assign count_after = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = align_word(redirect_pc);
      unique case (state_q)
        ST_REQ, ST_DRAIN: state_d = imem_ack ? ST_IDLE : ST_DRAIN;
        default:          state_d = ST_IDLE;
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_full) state_d = ST_REQ;
        end
        ST_REQ: begin
          if (imem_ack) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = (count_after < CW'(DEPTH)) ? ST_REQ : ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    imem_req_d  = (state_d == ST_REQ) || (state_d == ST_DRAIN);
    // A stale request keeps its original address until acknowledged
    imem_addr_d = (state_d == ST_DRAIN) ? imem_addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (imem_req_q && !imem_ack && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= 32'h0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: the word returned for an address is a fixed function of it
  assign imem_rdata = word_of(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.data = word_of(pc);
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    check("sb_drained", exp_q.size(), 0);
    exp_q.delete();
    reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    cyc();
    reset = 1'b1;
  endtask

  task automatic drain();
    imem_ack = 1'b0; instr_ready = 1'b1; redirect = 1'b0;
    repeat (4) cyc();
  endtask

  // Monitor: every transfer must match the oldest expected entry
  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_instr: got pc %h data %h, expected no transfer", instr_pc, instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mon_pc", instr_pc, e.pc);
        check("mon_instr", instr, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; instr_ready = 1'b0;

    // Streaming with ack tied high
    do_reset();
    imem_ack = 1'b1; instr_ready = 1'b1;
    @(negedge clk); check("a_idle", imem_req, 0); cyc();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("a_req", imem_req, 1);
      check("a_addr", imem_addr, 32'(4 * k));
      expect_fetch(32'(4 * k));
      cyc();
    end
    drain();

    // Backpressure fills the queue, one pop restarts fetch
    do_reset();
    imem_ack = 1'b1; instr_ready = 1'b0;
    @(negedge clk); check("b_idle", imem_req, 0); cyc();
    @(negedge clk); check("b_addr0", imem_addr, 32'h0); expect_fetch(32'h0); cyc();
    @(negedge clk); check("b_addr4", imem_addr, 32'h4); check("b_valid", instr_valid, 1);
    expect_fetch(32'h4); cyc();
    imem_ack = 1'b0; instr_ready = 1'b1;
    @(negedge clk); check("b_full_req", imem_req, 0); check("b_full_valid", instr_valid, 1);
    check("b_head_pc", instr_pc, 32'h0); cyc();
    instr_ready = 1'b0;
    @(negedge clk); check("b_wait_req", imem_req, 0); cyc();
    @(negedge clk); check("b_req8", imem_req, 1); check("b_addr8", imem_addr, 32'h8); cyc();
    drain();

    // Redirect while a request is pending, late ack is stale
    do_reset();
    imem_ack = 1'b1; instr_ready = 1'b1;
    @(negedge clk); cyc();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); check("c_addr", imem_addr, 32'(4 * k)); expect_fetch(32'(4 * k)); cyc();
    end
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk); check("c_addr10", imem_addr, 32'h10); check("c_redir_valid", instr_valid, 0);
    exp_q.delete(); cyc();
    redirect = 1'b0;
    repeat (2) begin
      @(negedge clk); check("c_drain_req", imem_req, 1); check("c_drain_addr", imem_addr, 32'h10);
      check("c_drain_valid", instr_valid, 0); cyc();
    end
    imem_ack = 1'b1;
    @(negedge clk); check("c_ack_addr", imem_addr, 32'h10); cyc();
    @(negedge clk); check("c_idle_req", imem_req, 0); check("c_idle_valid", instr_valid, 0); cyc();
    @(negedge clk); check("c_new_req", imem_req, 1); check("c_new_addr", imem_addr, 32'h100);
    expect_fetch(32'h100); cyc();
    drain();

    // Redirect coincident with ack
    do_reset();
    imem_ack = 1'b1; instr_ready = 1'b1;
    @(negedge clk); cyc();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); expect_fetch(32'(4 * k)); cyc();
    end
    redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk); check("d_addr10", imem_addr, 32'h10); check("d_redir_valid", instr_valid, 0);
    exp_q.delete(); cyc();
    redirect = 1'b0;
    @(negedge clk); check("d_idle_req", imem_req, 0); check("d_idle_valid", instr_valid, 0); cyc();
    @(negedge clk); check("d_addr40", imem_addr, 32'h40); expect_fetch(32'h40); cyc();
    @(negedge clk); check("d_addr44", imem_addr, 32'h44); expect_fetch(32'h44); cyc();
    drain();

    // fetch_pc wraps from the top of the address space
    do_reset();
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk); check("e_idle0", imem_req, 0); cyc();
    redirect = 1'b0;
    @(negedge clk); check("e_idle1", imem_req, 0); cyc();
    imem_ack = 1'b1;
    @(negedge clk); check("e_req", imem_req, 1); check("e_addr_top", imem_addr, 32'hFFFF_FFFC);
    expect_fetch(32'hFFFF_FFFC); cyc();
    imem_ack = 1'b0;
    @(negedge clk); check("e_addr_wrap", imem_addr, 32'h0); cyc();
    drain();

    // Reset mid-request, late ack after release is ignored
    do_reset();
    instr_ready = 1'b1;
    @(negedge clk); cyc();
    repeat (5) begin
      @(negedge clk); check("f_req", imem_req, 1); check("f_addr", imem_addr, 32'h0); cyc();
    end
    @(negedge clk);
`ifdef FETCH_STALL_CNT_EN
    check("f_stall5", stall_cnt, 32'd5);
`endif
    #1 reset = 1'b0;
    #1;
    check("f_rst_req", imem_req, 0);
    check("f_rst_valid", instr_valid, 0);
    check("f_rst_addr", imem_addr, 32'h0);
`ifdef FETCH_STALL_CNT_EN
    check("f_stall_clr", stall_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    imem_ack = 1'b1; reset = 1'b1;
    @(negedge clk); check("f_late_req", imem_req, 0); check("f_late_valid", instr_valid, 0); cyc();
    imem_ack = 1'b0;
    @(negedge clk); check("f_restart_req", imem_req, 1); check("f_restart_addr", imem_addr, 32'h0);
    check("f_no_push", instr_valid, 0); cyc();
    imem_ack = 1'b1;
    @(negedge clk); check("f_ack_addr", imem_addr, 32'h0); expect_fetch(32'h0); cyc();
    imem_ack = 1'b0;
    @(negedge clk); check("f_next_addr", imem_addr, 32'h4); cyc();
    drain();

    check("sb_final", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
